secp256k1_add_mod: RTL and testbench

SECP256K1_ADD_MOD -- requirements
Module: secp256k1_add_mod

---
 rtl/secp256k1_add_mod.sv | 145 ++++++++++++++
 tb/tb_secp256k1_add_mod.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/secp256k1_add_mod.sv
// secp256k1_add_mod: modular addition over the secp256k1 field prime.
// Operands are processed as four 64-bit limbs, least significant first.
// Phase one forms s = a + b and phase two forms t = s - P. FINAL then
// returns t or s depending on the top carry and the final borrow.
//
// state | meaning
// IDLE  | waiting for start; busy low
// ADD   | s[i] = a[i] + b[i] + carry, one limb per edge
// SUB   | t[i] = s[i] - P[i] - borrow, one limb per edge
// FINAL | select t or s into result, pulse done, return to IDLE
module secp256k1_add_mod #(
   parameter logic [255:0] P =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] a,
   input  logic [255:0] b,
   output logic [255:0] result,
   output logic         done,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SUB   = 2'd2,
      FINAL = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     idx_q;
   logic           carry_q;
   logic           borrow_q;
   logic           c256_q;
   logic           bw_q;
   logic [255:0]   a_q, b_q;
   logic [255:0]   s_q, t_q;
   logic [255:0]   result_q;
   logic           done_q;

   logic [7:0]     lsb;
   logic [63:0]    a_limb, b_limb, s_limb, p_limb;
   logic [64:0]    add_sum;
   logic [64:0]    sub_diff;
   logic           last_limb;

   // Limb selection and the 65-bit add/subtract for the current index.
   always_comb begin
      lsb       = {idx_q, 6'd0};
      a_limb    = a_q[lsb +: 64];
      b_limb    = b_q[lsb +: 64];
      s_limb    = s_q[lsb +: 64];
      p_limb    = P[lsb +: 64];
      add_sum   = {1'b0, a_limb} + {1'b0, b_limb} + {64'd0, carry_q};
      sub_diff  = {1'b0, s_limb} - {1'b0, p_limb} - {64'd0, borrow_q};
      last_limb = (idx_q == 2'd3);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ADD;
         ADD:     if (last_limb) state_d = SUB;
         SUB:     if (last_limb) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: busy is purely state based, result and done are registered.
   always_comb begin
      busy   = (state_q != IDLE);
      result = result_q;
      done   = done_q;
   end

   // Datapath: operand capture, limb-serial add and subtract, final select.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= 2'd0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         c256_q   <= 1'b0;
         bw_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         t_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= 1'b0;
                  idx_q   <= 2'd0;
               end
            end
            ADD: begin
               s_q[lsb +: 64] <= add_sum[63:0];
               carry_q        <= add_sum[64];
               if (last_limb) begin
                  c256_q   <= add_sum[64];
                  idx_q    <= 2'd0;
                  borrow_q <= 1'b0;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            SUB: begin
               t_q[lsb +: 64] <= sub_diff[63:0];
               borrow_q       <= sub_diff[64];
               if (last_limb) begin
                  bw_q  <= sub_diff[64];
                  idx_q <= 2'd0;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            FINAL: begin
               // A carry out of bit 255 or no borrow means s >= P.
               result_q <= (c256_q | ~bw_q) ? t_q : s_q;
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_secp256k1_add_mod.sv
// Testbench for secp256k1_add_mod: directed corner cases, control cases
// and randomized operands against a plain-arithmetic reference.
module tb_secp256k1_add_mod;

   localparam logic [255:0] P =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] a, b;
   logic [255:0] result;
   logic         done;
   logic         busy;

   int n_chk  = 0;
   int n_pass = 0;

   secp256k1_add_mod #(.P(P)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [255:0] ref_add(input logic [255:0] x, input logic [255:0] y);
      logic [256:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      return s[255:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   // Called at a negedge with busy low; returns at the negedge after E0
   // with start dropped and the inputs scrambled.
   task automatic issue(input logic [255:0] x, input logic [255:0] y);
      a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = rnd256();
      b = rnd256();
   endtask

   // Counts edges until done is seen at a negedge; n carries edges so far.
   task automatic wait_done(inout int n);
      while (!done && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [255:0] x, input logic [255:0] y);
      int n;
      n = 0;
      issue(x, y);
      check({tag, "_busy"}, 256'(busy), 256'(1));
      wait_done(n);
      check({tag, "_lat"}, 256'(n), 256'(9));
      check({tag, "_res"}, result, ref_add(x, y));
      check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
      @(negedge clk);
      check({tag, "_done_pulse"}, 256'(done), 256'(0));
      check({tag, "_res_held"}, result, ref_add(x, y));
   endtask

   initial begin
      int n;
      int dones;
      logic [255:0] x, y, x2, y2;

      // Reset with start asserted: start must be ignored.
      rst = 1'b1; start = 1'b1; a = 256'd5; b = 256'd6;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_result", result, 256'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      wait_done(n);
      check("first_accept_lat", 256'(n), 256'(9));
      check("first_accept_res", result, 256'd11);
      @(negedge clk);

      // Directed corner cases, including the explicit expected values.
      run_op("one_plus_two", 256'd1, 256'd2);
      check("one_plus_two_const", result, 256'd3);
      run_op("pm1_plus_1", P - 256'd1, 256'd1);
      check("pm1_plus_1_const", result, 256'd0);
      run_op("zero_zero", 256'd0, 256'd0);
      run_op("pm1_pm1", P - 256'd1, P - 256'd1);
      check("pm1_pm1_const", result,
            256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D);
      run_op("max_plus_0", {256{1'b1}}, 256'd0);
      check("max_plus_0_const", result, 256'h1000003D0);
      run_op("p_plus_0", P, 256'd0);
      run_op("max_max", {256{1'b1}}, {256{1'b1}});

      // start pulsed at E3 is ignored.
      x = rnd256(); y = rnd256();
      issue(x, y);
      n = 0;
      repeat (2) begin @(posedge clk); n++; end
      @(negedge clk);
      a = 256'd7; b = 256'd9; start = 1'b1;
      @(posedge clk); n++;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("ign_start_lat", 256'(n), 256'(9));
      check("ign_start_res", result, ref_add(x, y));
      dones = 0;
      repeat (12) begin @(posedge clk); @(negedge clk); if (done) dones++; end
      check("ign_start_no_second_done", 256'(dones), 256'(0));
      check("ign_start_idle", 256'(busy), 256'(0));

      // Back-to-back: start held in the done cycle.
      x = rnd256(); y = rnd256(); x2 = rnd256(); y2 = rnd256();
      issue(x, y);
      n = 0;
      wait_done(n);
      check("b2b_first_res", result, ref_add(x, y));
      issue(x2, y2);
      check("b2b_second_busy", 256'(busy), 256'(1));
      n = 0;
      wait_done(n);
      check("b2b_second_lat", 256'(n), 256'(9));
      check("b2b_second_res", result, ref_add(x2, y2));
      @(negedge clk);

      // Reset at E4 aborts with no done pulse.
      issue(rnd256(), rnd256());
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_result", result, 256'd0);
      check("abort_done", 256'(done), 256'(0));
      dones = 0;
      repeat (12) begin @(posedge clk); @(negedge clk); if (done) dones++; end
      check("abort_no_done", 256'(dones), 256'(0));
      run_op("after_abort", 256'd100, 256'd23);

      // Randomized operands, some biased to the top of the range.
      for (int k = 0; k < 30; k++) begin
         x = rnd256(); y = rnd256();
         if (k % 3 == 0) x = P - 256'($urandom_range(0, 4000));
         if (k % 5 == 0) y = {256{1'b1}} - 256'($urandom_range(0, 4000));
         run_op("rand", x, y);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
